// File: rtl/sram_1rw_arbiter.sv
// ----------------------------------------------------------------------------
// sram_1rw_arbiter
//
// Controller for one single-port, byte-masked SRAM macro with a one-cycle
// read latency. It shares the single RW port between a write requester and a
// read requester, zero-fills the whole array after reset or on request, and
// returns read data through a 2-entry in-order response FIFO with
// valid/ready backpressure.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   init_req / init_done  re-run the zero-fill / high while in RUN
//   w_valid/w_ready       write request handshake (w_addr, w_data, w_mask)
//   r_valid/r_ready       read request handshake (r_addr, r_id)
//   resp_valid/ready      response FIFO head handshake (resp_data, resp_id)
//   sram_*                macro drive; sram_rdata is valid the cycle after a
//                         read is issued
// ----------------------------------------------------------------------------
module sram_1rw_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 128,
   parameter int MASK_W     = 16,
   parameter int ID_W       = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              init_req,
   output logic              init_done,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [MASK_W-1:0] w_mask,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [ID_W-1:0]   r_id,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [ID_W-1:0]   resp_id,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
   localparam logic [SC_W-1:0]   STARVE_TOP = SC_W'(STARVE_MAX);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] init_ptr_q;
   logic              init_pend_q;   // init_req seen while a read was in flight
   logic [SC_W-1:0]   starve_q;
   logic              rd_inflight_q;
   logic [ID_W-1:0]   rd_id_q;

   // Response FIFO: two slots addressed by 1-bit pointers plus an occupancy count.
   logic [DATA_W-1:0] fifo_data_q [2];
   logic [ID_W-1:0]   fifo_id_q   [2];
   logic              fifo_rd_q, fifo_wr_q;
   logic [1:0]        fifo_cnt_q;

   logic       stop_grants, grants_open;
   logic [1:0] credit_used;
   logic       rd_credit, r_cand, w_cand, w_grant, r_grant;
   logic       fifo_nonempty, fifo_push, fifo_pop;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   assign stop_grants = init_req | init_pend_q;
   assign grants_open = (state_q == ST_RUN) & ~stop_grants;

   // A read needs a FIFO slot reserved for it; a same-cycle pop does not count.
   assign credit_used = fifo_cnt_q + {1'b0, rd_inflight_q};
   assign rd_credit   = (credit_used < 2'd2);

   assign r_cand  = grants_open & r_valid & rd_credit;
   assign w_cand  = grants_open & w_valid;
   // Reads win ties unless the waiting write has been starved long enough.
   assign w_grant = w_cand & (~r_cand | (starve_q == STARVE_TOP));
   assign r_grant = r_cand & ~w_grant;

   assign fifo_nonempty = (fifo_cnt_q != 2'd0);
   assign fifo_push     = rd_inflight_q;
   assign fifo_pop      = fifo_nonempty & resp_ready;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_INIT;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      // NOTE: a default on entry keeps every path assigned, so no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_INIT: if (init_ptr_q == LAST_ADDR)         state_d = ST_RUN;
         ST_RUN:  if (stop_grants && !rd_inflight_q)   state_d = ST_INIT;
         default:                                      state_d = ST_INIT;
      endcase
   end

   // FSM: outputs. Everything is held at zero during the reset cycle.
   always_comb begin
      init_done  = 1'b0;
      w_ready    = 1'b0;
      r_ready    = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_id    = '0;
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wmask = '0;
      sram_wdata = '0;
      if (!reset) begin
         init_done  = (state_q == ST_RUN);
         w_ready    = w_grant;
         r_ready    = r_grant;
         resp_valid = fifo_nonempty;
         if (fifo_nonempty) begin
            resp_data = fifo_data_q[fifo_rd_q];
            resp_id   = fifo_id_q[fifo_rd_q];
         end
         if (state_q == ST_INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_ptr_q;
            sram_wmask = '1;
         end else if (w_grant) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wmask = w_mask;
            sram_wdata = w_data;
         end else if (r_grant) begin
            sram_en    = 1'b1;
            sram_addr  = r_addr;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Sweep pointer, init request latch, starvation counter, read pipeline
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         init_ptr_q    <= '0;
         init_pend_q   <= 1'b0;
         starve_q      <= '0;
         rd_inflight_q <= 1'b0;
         rd_id_q       <= '0;
         fifo_rd_q     <= 1'b0;
         fifo_wr_q     <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         if (state_q == ST_INIT)
            init_ptr_q <= (init_ptr_q == LAST_ADDR) ? '0 : init_ptr_q + 1'b1;

         // Requests arriving during the sweep are dropped; in RUN the request
         // is held only until the outstanding read has landed.
         if (state_q == ST_RUN && init_req && rd_inflight_q) init_pend_q <= 1'b1;
         else if (state_q == ST_INIT || !rd_inflight_q)      init_pend_q <= 1'b0;

         if (w_grant || !w_valid)                     starve_q <= '0;
         else if (r_grant && starve_q != STARVE_TOP)  starve_q <= starve_q + 1'b1;

         rd_inflight_q <= r_grant;
         if (r_grant) rd_id_q <= r_id;

         if (fifo_push) fifo_wr_q <= ~fifo_wr_q;
         if (fifo_pop)  fifo_rd_q <= ~fifo_rd_q;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
      end
   end

   // NOTE: FIFO storage has no reset; the count and pointers alone decide what
   // is valid, and resp_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (fifo_push) begin
         fifo_data_q[fifo_wr_q] <= sram_rdata;
         fifo_id_q[fifo_wr_q]   <= rd_id_q;
      end
   end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_1rw_arbiter
//
// Self-checking bench for sram_1rw_arbiter. A behavioural SRAM macro answers
// the DUT's sram_* port. A transaction-level reference model (queue-based
// response FIFO, outstanding-read count, array image of memory contents)
// predicts every DUT output each cycle. Inputs change on the falling edge and
// outputs are compared 1 time unit later.
// ----------------------------------------------------------------------------
module tb_sram_1rw_arbiter;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 128;
   localparam int MASK_W     = 16;
   localparam int ID_W       = 4;
   localparam int STARVE_MAX = 4;
   localparam int DEPTH      = 4096;
   localparam int VEC_W      = 4 + ID_W + DATA_W + 2 + ADDR_W + MASK_W + DATA_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              init_req, init_done;
   logic              w_valid, w_ready;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [MASK_W-1:0] w_mask;
   logic              r_valid, r_ready;
   logic [ADDR_W-1:0] r_addr;
   logic [ID_W-1:0]   r_id;
   logic              resp_valid, resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic [ID_W-1:0]   resp_id;
   logic              sram_en, sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [MASK_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   sram_1rw_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
      .ID_W(ID_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clock(clock), .reset(reset),
      .init_req(init_req), .init_done(init_done),
      .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr),
      .w_data(w_data), .w_mask(w_mask),
      .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr), .r_id(r_id),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id),
      .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
      .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // ---------------------------------------------------------------- SRAM macro
   logic [DATA_W-1:0] sram_mem [DEPTH];
   logic [DATA_W-1:0] sram_word;

   always @(posedge clock) begin
      if (sram_en) begin
         if (sram_wmode) begin
            sram_word = sram_mem[sram_addr];
            for (int b = 0; b < MASK_W; b++)
               if (sram_wmask[b]) sram_word[8*b +: 8] = sram_wdata[8*b +: 8];
            sram_mem[sram_addr] <= sram_word;
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   // ----------------------------------------------------------- reference model
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   id;
   } resp_t;

   resp_t             m_q[$];          // responses waiting for the consumer
   resp_t             m_rd;            // read whose data is on sram_rdata next
   bit                m_has_rd;
   logic [DATA_W-1:0] m_mem [DEPTH];   // what the array should hold
   bit                m_run, m_pend;
   int                m_ptr, m_starve;
   bit                m_gw, m_gr;
   logic [VEC_W-1:0]  exp_vec;

   function automatic logic [DATA_W-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [VEC_W-1:0] dut_vec();
      return {init_done, w_ready, r_ready, resp_valid, resp_id, resp_data,
              sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};
   endfunction

   // Predict this cycle's outputs from the model state and the current inputs.
   task automatic model_eval();
      logic              e_done, e_wr, e_rr, e_rv, e_en, e_wm;
      logic [ID_W-1:0]   e_id;
      logic [DATA_W-1:0] e_rd, e_wd;
      logic [ADDR_W-1:0] e_a;
      logic [MASK_W-1:0] e_mk;
      bit                stop, can_r, can_w;
      int                outstanding;
      {e_done, e_wr, e_rr, e_rv, e_en, e_wm} = '0;
      e_id = '0; e_rd = '0; e_wd = '0; e_a = '0; e_mk = '0;
      m_gw = 1'b0;
      m_gr = 1'b0;
      if (!reset) begin
         e_done = m_run;
         if (m_q.size() > 0) begin
            e_rv = 1'b1;
            e_id = m_q[0].id;
            e_rd = m_q[0].data;
         end
         if (!m_run) begin
            e_en = 1'b1; e_wm = 1'b1; e_a = ADDR_W'(m_ptr); e_mk = '1;
         end else begin
            stop        = init_req || m_pend;
            outstanding = m_q.size() + (m_has_rd ? 1 : 0);
            can_r       = !stop && r_valid && (outstanding < 2);
            can_w       = !stop && w_valid;
            if (can_w && can_r) begin
               m_gw = (m_starve >= STARVE_MAX);
               m_gr = !m_gw;
            end else begin
               m_gw = can_w;
               m_gr = can_r;
            end
            if (m_gw) begin
               e_wr = 1'b1; e_en = 1'b1; e_wm = 1'b1;
               e_a = w_addr; e_mk = w_mask; e_wd = w_data;
            end else if (m_gr) begin
               e_rr = 1'b1; e_en = 1'b1; e_a = r_addr;
            end
         end
      end
      exp_vec = {e_done, e_wr, e_rr, e_rv, e_id, e_rd, e_en, e_wm, e_a, e_mk, e_wd};
   endtask

   // Advance the model across the rising edge.
   task automatic model_commit();
      bit busy;
      if (reset) begin
         m_run = 0; m_ptr = 0; m_pend = 0; m_has_rd = 0; m_starve = 0;
         m_q.delete();
         return;
      end
      busy = m_has_rd;
      if (m_q.size() > 0 && resp_ready) void'(m_q.pop_front());
      if (m_has_rd) begin
         m_q.push_back(m_rd);
         m_has_rd = 0;
      end
      if (m_gr) begin
         m_rd     = '{data: m_mem[r_addr], id: r_id};
         m_has_rd = 1;
      end
      if (m_gw)
         for (int b = 0; b < MASK_W; b++)
            if (w_mask[b]) m_mem[w_addr][8*b +: 8] = w_data[8*b +: 8];
      if (m_gw || !w_valid) m_starve = 0;
      else if (m_gr)        m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      if (!m_run) begin
         m_mem[m_ptr] = '0;
         m_pend = 0;
         if (m_ptr == DEPTH - 1) begin
            m_run = 1;
            m_ptr = 0;
         end else begin
            m_ptr++;
         end
      end else if (init_req || m_pend) begin
         if (!busy) begin
            m_run  = 0;
            m_pend = 0;
         end else begin
            m_pend = 1;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic advance();
      model_commit();
      @(negedge clock);
   endtask

   // --------------------------------------------------------- stimulus helpers
   task automatic set_idle();
      init_req   = 1'b0;
      w_valid    = 1'b0;
      r_valid    = 1'b0;
      resp_ready = 1'b1;
      w_addr     = '0;
      w_data     = '0;
      w_mask     = '0;
      r_addr     = '0;
      r_id       = '0;
   endtask

   task automatic set_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [MASK_W-1:0] m);
      w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
   endtask

   task automatic set_read(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
      r_valid = 1'b1; r_addr = a; r_id = id;
   endtask

   task automatic set_random(input bit allow_init);
      init_req   = allow_init && ($urandom_range(7) == 0);
      w_valid    = $urandom_range(1);
      r_valid    = $urandom_range(1);
      resp_ready = $urandom_range(1);
      w_addr     = ADDR_W'(12'h020 + $urandom_range(15));
      w_data     = rand_data();
      w_mask     = MASK_W'($urandom);
      r_addr     = ADDR_W'(12'h020 + $urandom_range(15));
      r_id       = ID_W'($urandom);
   endtask

   // -------------------------------------------------------------------- tests
   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_random(1'b1);
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL reset_outputs t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec);
         end
         advance();
      end
      reset = 1'b0;
   endtask

   task automatic test_init_sweep();
      for (int i = 0; i <= DEPTH + 1; i++) begin
         set_random(i < DEPTH);
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL sweep i=%0d got=%h exp=%h", i, dut_vec(), exp_vec);
         end
         if (i == 0) begin
            checks++;
            if ({sram_en, sram_wmode, sram_addr} !== {2'b11, 12'h000}) begin
               errors++;
               $display("FAIL sweep_first got en/wm/addr=%b/%b/%h exp 1/1/000",
                        sram_en, sram_wmode, sram_addr);
            end
         end
         if (i == DEPTH - 1 || i == DEPTH) begin
            checks++;
            if (init_done !== (i == DEPTH)) begin
               errors++;
               $display("FAIL init_done_edge i=%0d got=%b exp=%b", i, init_done, i == DEPTH);
            end
         end
         advance();
      end
      set_idle();
   endtask

   task automatic test_write_read();
      logic [DATA_W-1:0] exp_data;
      logic [DATA_W-1:0] got_data;
      logic [ID_W-1:0]   got_id;
      int                lat;
      exp_data = {64'h0, {8{8'hA5}}};
      lat      = -1;
      got_data = '0;
      got_id   = '0;
      set_idle();
      set_write(12'h010, {16{8'hA5}}, 16'h00FF);
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
         errors++;
         $display("FAIL wr_grant got=%h exp=%h", dut_vec(), exp_vec);
      end
      advance();
      set_idle();
      set_read(12'h010, 4'd3);
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
         errors++;
         $display("FAIL rd_grant got=%h exp=%h", dut_vec(), exp_vec);
      end
      advance();
      set_idle();
      for (int k = 1; k <= 6 && lat < 0; k++) begin
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL rd_wait k=%0d got=%h exp=%h", k, dut_vec(), exp_vec);
         end
         if (resp_valid === 1'b1) begin
            lat      = k;
            got_data = resp_data;
            got_id   = resp_id;
         end
         advance();
      end
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL rd_latency got=%0d exp=2", lat);
      end
      checks++;
      if ({got_id, got_data} !== {4'd3, exp_data}) begin
         errors++;
         $display("FAIL rd_masked_data got id=%0d data=%h exp id=3 data=%h", got_id, got_data, exp_data);
      end
   endtask

   // A write in the cycle after a read to the same address must not leak into
   // the captured data.
   task automatic test_read_then_write();
      logic [DATA_W-1:0] old_val, new_val, got;
      bit                seen;
      old_val = rand_data();
      new_val = ~old_val;
      seen    = 0;
      got     = '0;
      for (int c = 0; c < 8; c++) begin
         set_idle();
         if (c == 0) set_write(12'h030, old_val, '1);
         if (c == 1) set_read(12'h030, 4'd7);
         if (c == 2) set_write(12'h030, new_val, '1);
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL rw_hazard c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         if (resp_valid === 1'b1 && !seen) begin
            seen = 1;
            got  = resp_data;
         end
         advance();
      end
      checks++;
      if (!seen || got !== old_val) begin
         errors++;
         $display("FAIL rw_hazard_old seen=%0d got=%h exp=%h", seen, got, old_val);
      end
      set_idle();
   endtask

   task automatic test_contention();
      string order;
      order = "";
      for (int c = 0; c < 14; c++) begin
         set_idle();
         if (c < 10) begin
            set_write(ADDR_W'(12'h040 + c), rand_data(), MASK_W'($urandom));
            set_read(ADDR_W'(12'h040 + $urandom_range(15)), ID_W'(c));
         end
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL contention c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         if (c < 10) order = {order, w_ready ? "W" : (r_ready ? "R" : "-")};
         advance();
      end
      $display("contention grant order: %s", order);
   endtask

   task automatic test_backpressure();
      int accepted;
      accepted = 0;
      for (int c = 0; c < 8; c++) begin
         set_idle();
         resp_ready = (c >= 6);
         set_read(ADDR_W'(12'h050 + c), ID_W'(c));
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL backpressure c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         if (c < 6 && r_ready === 1'b1) accepted++;
         if (c == 6 || c == 7) begin
            checks++;
            if (r_ready !== (c == 7)) begin
               errors++;
               $display("FAIL bp_release c=%0d r_ready got=%b exp=%b", c, r_ready, c == 7);
            end
         end
         advance();
      end
      checks++;
      if (accepted != 2) begin
         errors++;
         $display("FAIL bp_accepted got=%0d exp=2", accepted);
      end
      set_idle();
      for (int c = 0; c < 4; c++) begin
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL bp_drain c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         set_random(1'b0);
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         advance();
      end
      set_idle();
      for (int c = 0; c < 4; c++) begin
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL random_drain c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         advance();
      end
   endtask

   // init_req while a read is in flight: the read lands, then a full sweep,
   // after which the previously written word reads back as zero.
   task automatic test_init_req();
      logic [DATA_W-1:0] got;
      bit                seen;
      seen = 0;
      got  = '1;
      for (int c = 0; c < DEPTH + 20; c++) begin
         set_idle();
         if (c == 0) set_read(12'h010, 4'd5);
         if (c == 1) init_req = 1'b1;
         if (c == DEPTH + 8) set_read(12'h010, 4'd9);
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL init_req c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         if (c > DEPTH + 8 && resp_valid === 1'b1 && !seen) begin
            seen = 1;
            got  = resp_data;
         end
         advance();
      end
      checks++;
      if (!seen || got !== '0) begin
         errors++;
         $display("FAIL resweep_zero seen=%0d got=%h exp=0", seen, got);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      set_idle();
      resp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         set_idle();
         resp_ready = 1'b0;
         if (c < 4) set_read(ADDR_W'(12'h060 + c), ID_W'(c));
         if (c == 4) init_req = 1'b1;
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL mr_fill c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         advance();
      end
      n = 0;
      while (!(!m_run && m_ptr == 100) && n < 300) begin
         set_random(1'b1);
         resp_ready = 1'b0;
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL mr_sweep n=%0d got=%h exp=%h", n, dut_vec(), exp_vec);
         end
         advance();
         n++;
      end
      checks++;
      if (n >= 300 || resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL mr_reach_ptr100 cycles=%0d resp_valid got=%b exp=1", n, resp_valid);
      end
      reset = 1'b1;
      set_random(1'b1);
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
         errors++;
         $display("FAIL mr_reset got=%h exp=%h", dut_vec(), exp_vec);
      end
      advance();
      reset = 1'b0;
      set_idle();
      settle();
      checks++;
      if ({sram_en, sram_addr, resp_valid} !== {1'b1, 12'h000, 1'b0}) begin
         errors++;
         $display("FAIL mr_restart got en/addr/resp_valid=%b/%h/%b exp 1/000/0",
                  sram_en, sram_addr, resp_valid);
      end
      advance();
      for (int c = 1; c <= DEPTH + 2; c++) begin
         set_idle();
         settle();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL mr_resweep c=%0d got=%h exp=%h", c, dut_vec(), exp_vec);
         end
         advance();
      end
   endtask

   // -------------------------------------------------------------------- main
   initial begin
      reset = 1'b1;
      set_idle();
      m_run = 0; m_ptr = 0; m_pend = 0; m_has_rd = 0; m_starve = 0;
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = rand_data();
      @(negedge clock);
      test_reset();
      test_init_sweep();
      test_write_read();
      test_read_then_write();
      test_contention();
      test_backpressure();
      test_random();
      test_init_req();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
